// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if
// Bundles the ID/EX/MEM hazard inputs and the pipeline control outputs of the
// hazard/stall controller.
//   master : pipeline side, which drives the decode/EX/MEM fields and reads the controls
//   slave  : hazard_ctrl_unit, which reads the fields and drives the controls
// Parameters: REG_AW register address width, CNT_W performance counter width.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_beq;
  logic              id_bne;
  logic              id_jump;
  logic              id_equal;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_rd;
  logic              ex_md_start;

  logic              pc_write;
  logic              ifid_write;
  logic              idex_write;
  logic              idex_bubble;
  logic              if_flush;
  logic              md_busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_beq, id_bne, id_jump, id_equal,
           ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd, ex_md_start,
    input  pc_write, ifid_write, idex_write, idex_bubble, if_flush, md_busy,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_beq, id_bne, id_jump, id_equal,
           ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd, ex_md_start,
    output pc_write, ifid_write, idex_write, idex_bubble, if_flush, md_busy,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Hazard/stall controller for a 5-stage MIPS pipeline, placed beside ID.
// It detects load-use, ALU-to-branch and load-to-branch hazards, freezes the
// front end while a multi-cycle MULT/DIV occupies EX, suppresses the IF flush
// while stalled, and keeps saturating stall and flush counters.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   hz_if slave view of hazard_ctrl_unit_if (hazard inputs, control outputs, counters)
//
// state  | meaning
// -------+------------------------------------------------------------------
// ST_RUN | normal issue; the hazard terms decide stall, bubble or flush
// ST_MD  | MULT/DIV busy in EX; front end and ID/EX are frozen
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_ctrl_unit_if.slave  hz_if
);

  localparam int MD_CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MD_CW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic dep_e, dep_m, br, lu, br_e, br_m, hz;
  logic frozen;
  logic pc_write, ifid_write, idex_write, idex_bubble, if_flush;

  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    dep_e = (hz_if.ex_rd != '0) &&
            ((hz_if.ex_rd == hz_if.id_rs) ||
             (hz_if.id_uses_rt && (hz_if.ex_rd == hz_if.id_rt)));
    dep_m = (hz_if.mem_rd != '0) &&
            ((hz_if.mem_rd == hz_if.id_rs) ||
             (hz_if.id_uses_rt && (hz_if.mem_rd == hz_if.id_rt)));
    br    = hz_if.id_beq | hz_if.id_bne;
    lu    = hz_if.ex_mem_read & dep_e;
    br_e  = br & hz_if.ex_reg_write & dep_e;
    br_m  = br & hz_if.mem_mem_read & dep_m;
    hz    = lu | br_e | br_m;
  end

  // While rst is high the outputs behave as in RUN, so a reset arriving in
  // the middle of a busy period does not hold the pipeline for that cycle.
  assign frozen = (state_q == ST_MD) && !rst;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    if_flush    = 1'b0;
    if (frozen) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (hz) begin
      // The branch resolves only once its operands are available, so the
      // flush waits until the stall clears.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      if_flush = hz_if.id_jump |
                 (hz_if.id_beq & hz_if.id_equal) |
                 (hz_if.id_bne & ~hz_if.id_equal);
    end
  end

  // The busy counter loads MD_LAT-1 on the start cycle and releases EX on
  // the cycle it reads 1, giving exactly MD_LAT-1 frozen cycles.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (hz_if.ex_md_start) begin
          state_d  = ST_MD;
          md_cnt_d = MD_CW'(MD_LAT - 1);
        end
      end
      ST_MD: begin
        md_cnt_d = md_cnt_q - MD_CW'(1);
        if (md_cnt_q == MD_CW'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz_if.pc_write    = pc_write;
  assign hz_if.ifid_write  = ifid_write;
  assign hz_if.idex_write  = idex_write;
  assign hz_if.idex_bubble = idex_bubble;
  assign hz_if.if_flush    = if_flush;
  assign hz_if.md_busy     = frozen;
  assign hz_if.stall_cnt   = stall_cnt_q;
  assign hz_if.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
// Directed scenarios followed by random traffic; every cycle's outputs are
// compared with a behavioural reference model of the hazard rules.
module tb_hazard_ctrl_unit;
  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

  hazard_ctrl_unit #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .hz_if (hif.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int busy_left = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  int busy_seen = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit depends(input logic [REG_AW-1:0] rd);
    return (rd != 0) && ((rd == hif.id_rs) || (hif.id_uses_rt && (rd == hif.id_rt)));
  endfunction

  task automatic clear_inputs();
    hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rt = 1'b0;
    hif.id_beq = 1'b0; hif.id_bne = 1'b0; hif.id_jump = 1'b0; hif.id_equal = 1'b0;
    hif.ex_mem_read = 1'b0; hif.ex_reg_write = 1'b0; hif.ex_rd = '0;
    hif.mem_mem_read = 1'b0; hif.mem_rd = '0; hif.ex_md_start = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic step(input string tag);
    bit busy, br, hz, taken;
    int e_pc, e_ifid, e_idex, e_bub, e_fl;
    @(negedge clk);
    busy  = (busy_left > 0) && !rst;
    br    = hif.id_beq || hif.id_bne;
    hz    = (hif.ex_mem_read && depends(hif.ex_rd)) ||
            (br && hif.ex_reg_write && depends(hif.ex_rd)) ||
            (br && hif.mem_mem_read && depends(hif.mem_rd));
    taken = hif.id_jump || (hif.id_beq && hif.id_equal) || (hif.id_bne && !hif.id_equal);
    if (busy) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_bub = 0; e_fl = 0;
    end else if (hz) begin
      e_pc = 0; e_ifid = 0; e_idex = 1; e_bub = 1; e_fl = 0;
    end else begin
      e_pc = 1; e_ifid = 1; e_idex = 1; e_bub = 0; e_fl = taken ? 1 : 0;
    end
    chk({tag, ".pc_write"},    int'(hif.pc_write),    e_pc);
    chk({tag, ".ifid_write"},  int'(hif.ifid_write),  e_ifid);
    chk({tag, ".idex_write"},  int'(hif.idex_write),  e_idex);
    chk({tag, ".idex_bubble"}, int'(hif.idex_bubble), e_bub);
    chk({tag, ".if_flush"},    int'(hif.if_flush),    e_fl);
    chk({tag, ".md_busy"},     int'(hif.md_busy),     busy ? 1 : 0);
    chk({tag, ".stall_cnt"},   int'(hif.stall_cnt),   m_stall);
    chk({tag, ".flush_cnt"},   int'(hif.flush_cnt),   m_flush);
    if (busy) busy_seen++;
    @(posedge clk);
    if (rst) begin
      busy_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_pc == 0 && m_stall < CNT_MAX) m_stall++;
      if (e_fl == 1 && m_flush < CNT_MAX) m_flush++;
      if (busy_left > 0) busy_left--;
      else if (hif.ex_md_start) busy_left = MD_LAT - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    do_reset();
    chk("reset.stall_cnt", int'(hif.stall_cnt), 0);
    chk("reset.md_busy",   int'(hif.md_busy),   0);

    // load-use on rs, then the same with $zero as destination
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd8; hif.id_rs = 5'd8;
    step("lu");
    chk("lu.stall_after", int'(hif.stall_cnt), 1);
    hif.ex_rd = 5'd0; hif.id_rs = 5'd0;
    step("lu_r0");
    chk("lu_r0.stall_after", int'(hif.stall_cnt), 1);

    // rt matches only when the instruction actually reads rt
    do_reset();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd9; hif.id_rt = 5'd9; hif.id_rs = 5'd3;
    hif.id_uses_rt = 1'b0;
    step("rt_unused");
    hif.id_uses_rt = 1'b1;
    step("rt_used");
    chk("rt.stall_after", int'(hif.stall_cnt), 1);

    // lw $t0 ; beq $t0,$t1 (taken): two stall cycles then a single flush
    do_reset();
    hif.id_beq = 1'b1; hif.id_equal = 1'b1; hif.id_rs = 5'd8; hif.id_rt = 5'd9;
    hif.id_uses_rt = 1'b1;
    hif.ex_mem_read = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = 5'd8;
    step("lb_c1");
    hif.ex_mem_read = 1'b0; hif.ex_reg_write = 1'b0; hif.ex_rd = 5'd0;
    hif.mem_mem_read = 1'b1; hif.mem_rd = 5'd8;
    step("lb_c2");
    hif.mem_mem_read = 1'b0; hif.mem_rd = 5'd0;
    step("lb_c3");
    chk("lb.stall_cnt", int'(hif.stall_cnt), 2);
    chk("lb.flush_cnt", int'(hif.flush_cnt), 1);

    // ALU producer feeding a bne that ends up taken
    do_reset();
    hif.id_bne = 1'b1; hif.id_equal = 1'b0; hif.id_rs = 5'd10; hif.id_rt = 5'd11;
    hif.id_uses_rt = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = 5'd10;
    step("ab_c1");
    hif.ex_reg_write = 1'b0; hif.ex_rd = 5'd0;
    step("ab_c2");
    chk("ab.stall_cnt", int'(hif.stall_cnt), 1);
    chk("ab.flush_cnt", int'(hif.flush_cnt), 1);

    // MULT/DIV: three frozen cycles, restart ignored, jump held throughout
    do_reset();
    hif.id_jump = 1'b1;
    hif.ex_md_start = 1'b1;
    step("md_start");
    busy_seen = 0;
    hif.ex_md_start = 1'b0;
    step("md_b1");
    hif.ex_md_start = 1'b1;
    step("md_b2");
    hif.ex_md_start = 1'b0;
    step("md_b3");
    step("md_done");
    chk("md.busy_cycles", busy_seen, MD_LAT - 1);
    chk("md.stall_cnt", int'(hif.stall_cnt), 3);
    chk("md.flush_cnt", int'(hif.flush_cnt), 2);

    // stall counter saturates, then reset aborts a busy period
    do_reset();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd8; hif.id_rs = 5'd8;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.stall_cnt", int'(hif.stall_cnt), CNT_MAX);
    clear_inputs();
    hif.ex_md_start = 1'b1;
    step("rmd_start");
    hif.ex_md_start = 1'b0;
    step("rmd_busy");
    rst = 1'b1;
    step("rmd_rst");
    rst = 1'b0;
    step("rmd_after");
    chk("rmd.md_busy", int'(hif.md_busy), 0);

    // random traffic with a small register range to force collisions
    for (int n = 0; n < 400; n++) begin
      hif.id_rs        = REG_AW'($urandom_range(0, 3));
      hif.id_rt        = REG_AW'($urandom_range(0, 3));
      hif.id_uses_rt   = 1'($urandom_range(0, 1));
      hif.id_beq       = 1'($urandom_range(0, 1));
      hif.id_bne       = ($urandom_range(0, 3) == 0);
      hif.id_jump      = ($urandom_range(0, 5) == 0);
      hif.id_equal     = 1'($urandom_range(0, 1));
      hif.ex_mem_read  = ($urandom_range(0, 2) == 0);
      hif.ex_reg_write = 1'($urandom_range(0, 1));
      hif.ex_rd        = REG_AW'($urandom_range(0, 3));
      hif.mem_mem_read = ($urandom_range(0, 2) == 0);
      hif.mem_rd       = REG_AW'($urandom_range(0, 3));
      hif.ex_md_start  = ($urandom_range(0, 9) == 0);
      rst              = ($urandom_range(0, 59) == 0);
      step("rnd");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
